// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the pipelined add/sub datapath.
//   - op encoding for the sub select
//   - ALU datapath width and legal WIDTH range
//   - packed stage-1 payload (raw sum, carry, op)
package addsub_pkg;

  localparam logic ADDSUB_OP_ADD = 1'b0;
  localparam logic ADDSUB_OP_SUB = 1'b1;

  // Width the ALU result mux expects from this block
  localparam int unsigned ADDSUB_ALU_WIDTH = 4;
  localparam int unsigned ADDSUB_MIN_WIDTH = 2;
  // Payload is sized for the widest supported instance; narrower ones zero-pad
  localparam int unsigned ADDSUB_MAX_WIDTH = 32;

  typedef struct packed {
    logic [ADDSUB_MAX_WIDTH-1:0] raw;  // raw[WIDTH-1:0] of A + (B^sub) + sub
    logic                        c;    // raw[WIDTH]
    logic                        sub;
  } addsub_s1_t;

endpackage

// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if: valid/ready operand and result bus of addsub_pipe.
//   master: producer of operands / consumer of results
//   slave : the add/sub pipeline
//   in_valid/in_ready/a/b/sub         : operand transfer
//   out_valid/out_ready/result/neg/cout/ovf : result transfer
interface addsub_pipe_if #(
  parameter int unsigned WIDTH = addsub_pkg::ADDSUB_ALU_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             neg;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, neg, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, neg, cout, ovf
  );

endinterface

// File: rtl/addsub_rca.sv
// addsub_rca: combinational WIDTH-bit ripple-carry adder.
//   a, b    : addends
//   cin     : carry in
//   sum_c   : a + b + cin, low WIDTH bits
//   cout_c  : carry out of the top bit
module addsub_rca #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum_c,
  output logic             cout_c
);

  logic [WIDTH:0] carry;

  // Bit-serial carry chain
  always_comb begin
    carry    = '0;
    sum_c    = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum_c[i]   = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout_c = carry[WIDTH];
  end

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: two-stage pipelined unsigned adder/subtractor, valid/ready.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : addsub_pipe_if.slave (operands in, result/neg/cout/ovf out)
// S1 registers the raw two's-complement add; S2 turns a borrowing
// subtraction into magnitude + neg and registers the result fields.
// Build option: define ADDSUB_SAT_EN to saturate overflowing adds to all-ones.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = ADDSUB_ALU_WIDTH
) (
  input logic         clk,
  input logic         rst,
  addsub_pipe_if.slave bus
);

  if (WIDTH < ADDSUB_MIN_WIDTH || WIDTH > ADDSUB_MAX_WIDTH) begin : g_width_chk
    $error("addsub_pipe: WIDTH outside supported range");
  end

  logic             s1_valid_q;
  addsub_s1_t       s1_d;
  addsub_s1_t       s1_q;
  logic             s2_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             neg_q;
  logic             cout_q;
  logic             ovf_q;

  logic             in_xfer;
  logic             s2_load;
  logic             out_xfer;

  // Handshake: S1 frees up whenever S2 can take its contents
  assign bus.in_ready = !s1_valid_q || !s2_valid_q || bus.out_ready;
  assign in_xfer      = bus.in_valid && bus.in_ready;
  assign out_xfer     = s2_valid_q && bus.out_ready;
  assign s2_load      = s1_valid_q && (!s2_valid_q || bus.out_ready);

  // Stage 1: A + ~B + 1 for subtract, A + B for add
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] raw_sum_c;
  logic             raw_cout_c;

  assign b_sel = bus.b ^ {WIDTH{bus.sub}};

  addsub_rca #(.WIDTH(WIDTH)) u_rca_raw (
    .a      (bus.a),
    .b      (b_sel),
    .cin    (bus.sub),
    .sum_c  (raw_sum_c),
    .cout_c (raw_cout_c)
  );

  always_comb begin
    s1_d     = '0;
    s1_d.raw = ADDSUB_MAX_WIDTH'(raw_sum_c);
    s1_d.c   = raw_cout_c;
    s1_d.sub = bus.sub;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (in_xfer) begin
      s1_valid_q <= 1'b1;
      s1_q       <= s1_d;
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage 2: negate a borrowed difference back to its magnitude
  logic [WIDTH-1:0] raw_lo;
  logic [WIDTH-1:0] mag_c;
  logic             unused_mag_cout;

  assign raw_lo = s1_q.raw[WIDTH-1:0];

  addsub_rca #(.WIDTH(WIDTH)) u_rca_neg (
    .a      (~raw_lo),
    .b      ({WIDTH{1'b0}}),
    .cin    (1'b1),
    .sum_c  (mag_c),
    .cout_c (unused_mag_cout)
  );

  if (WIDTH < ADDSUB_MAX_WIDTH) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^s1_q.raw[ADDSUB_MAX_WIDTH-1:WIDTH];
  end

  logic [WIDTH-1:0] result_d;
  logic             neg_d;
  logic             cout_d;
  logic             ovf_d;

  // c=1 on subtract means no borrow, so a zero difference stays non-negative
  always_comb begin
    result_d = raw_lo;
    neg_d    = 1'b0;
    cout_d   = s1_q.c;
    ovf_d    = 1'b0;
    if (s1_q.sub == ADDSUB_OP_SUB) begin
      if (!s1_q.c) begin
        result_d = mag_c;
        neg_d    = 1'b1;
      end
    end else begin
      ovf_d = s1_q.c;
`ifdef ADDSUB_SAT_EN
      if (s1_q.c) begin
        result_d = '1;
      end
`else
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      neg_q      <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= 1'b1;
      result_q   <= result_d;
      neg_q      <= neg_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
    end else if (out_xfer) begin
      s2_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.result    = result_q;
  assign bus.neg       = neg_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, two-stage pipelined unsigned adder/subtractor with a valid/ready handshake. A subtraction that borrows is returned as a magnitude plus a negative flag, never as a raw two's-complement word. It replaces the fixed 4-bit combinational add/sub-with-magnitude-correction path in the ALU datapath. It sits between the operand-select stage and the ALU result mux.

## Interface
- `WIDTH`, default 4: operand and result width in bits; must be ≥ 2.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: operands and op on the input are valid.
- `in_ready` output, 1 bit: block accepts an input this cycle.
- `a` input, WIDTH bits: operand A, unsigned.
- `b` input, WIDTH bits: operand B, unsigned.
- `sub` input, 1 bit: 0 computes A+B; 1 computes A−B.
- `out_valid` output, 1 bit: result fields are valid.
- `out_ready` input, 1 bit: consumer accepts the result this cycle.
- `result` output, WIDTH bits: sum, or difference magnitude.
- `neg` output, 1 bit: subtraction result is negative (A<B).
- `cout` output, 1 bit: adder carry-out. On subtraction, 1 means no borrow.
- `ovf` output, 1 bit: unsigned add overflow (A+B ≥ 2^WIDTH). Always 0 on subtraction.

## Operation
- Input transfer happens when `in_valid && in_ready`. Output transfer happens when `out_valid && out_ready`.
- Stage 1 (S1) registers the raw result `raw = A + (B ^ {WIDTH{sub}}) + sub`, computed at WIDTH+1 bits. It also registers `c = raw[WIDTH]` and `sub`.
- Stage 2 (S2) applies the magnitude correction:
  - Add: `result = raw[WIDTH-1:0]`, `neg = 0`, `cout = c`, `ovf = c`.
  - Sub with c=1 (A≥B): `result = raw[WIDTH-1:0]`, `neg = 0`, `cout = 1`.
  - Sub with c=0 (A<B): `result = (~raw[WIDTH-1:0]) + 1` (mod 2^WIDTH), `neg = 1`, `cout = 0`.
- A zero difference (A==B) gives `result = 0`, `neg = 0`, `cout = 1`. It never reports a negative zero.
- Each stage holds a valid bit. A stage loads when it is empty or when its downstream transfers in the same cycle.
- `in_ready = !s1_valid || !s2_valid || out_ready`. This is a combinational path from `out_ready`, which is accepted.
- While `out_valid && !out_ready`, the output fields stay stable and ordering is preserved. No transaction is dropped or duplicated.

## Timing
- Latency: 2 cycles from input transfer to `out_valid`, assuming no stall.
- Throughput: 1 operation per cycle while `out_ready` stays high.
- Pipeline capacity: 2 operations. If `out_ready` stays low, `in_ready` deasserts in the cycle after the second accept.
- Simultaneous input and output transfer with both stages full: S2 takes S1's contents and S1 takes the new input in the same cycle.
- Reset values: `out_valid`, `result`, `neg`, `cout` and `ovf` all go to 0. `in_ready` goes to 1 once both stages are empty.
- Reset asserted mid-operation discards every in-flight transaction. `out_valid` drops asynchronously, with no completion afterwards.

## Configuration
- Macro `ADDSUB_SAT_EN`:
  - Defined: an unsigned add with overflow returns `result = {WIDTH{1'b1}}`, with `ovf = 1` and `cout = 1` still reported. Subtraction is unaffected.
  - Undefined: an add with overflow returns the wrapped sum `raw[WIDTH-1:0]`.
- The pipeline timing is identical in both builds.

## Structure
- Shared package `addsub_pkg` holds:
  - op encoding constants `ADDSUB_OP_ADD = 1'b0` and `ADDSUB_OP_SUB = 1'b1`;
  - a packed struct for the S1 payload: raw, c, sub;
  - the shared width-check constant for the ALU.
- One sub-module, `addsub_rca`: a combinational WIDTH-bit ripple adder with carry-in and carry-out.
  - Instantiated once in S1 for the raw add.
  - Instantiated once in S2 for the +1 of the two's-complement correction, with B=0 and cin=1.

## Test plan
- WIDTH=4, add 5+3 → `result = 8`, `neg = 0`, `cout = 0`, `ovf = 0`, exactly 2 cycles after accept.
- WIDTH=4, sub 3−5 → `result = 2`, `neg = 1`, `cout = 0`. Sub 7−7 → `result = 0`, `neg = 0`, `cout = 1`.
- WIDTH=4, add 9+9:
  - without `ADDSUB_SAT_EN` → `result = 2`, `cout = 1`, `ovf = 1`;
  - with `ADDSUB_SAT_EN` → `result = 15`, `ovf = 1`.
- Backpressure: hold `out_ready = 0` and offer 3 back-to-back ops (1+1, 2+2, 3+3).
  - `in_ready` falls after 2 accepts.
  - After release, the results come out as 2, 4, 6 in order, one per cycle.
  - The third op is accepted only in the first cycle `out_ready` is high.
- WIDTH=8, random A/B/sub, 1000 ops with random `out_ready`. Each output must match the reference model: magnitude |A−B| with `neg = (A<B)` for subtraction, `(A+B) mod 256` with `ovf` for addition.
- Assert `rst` with 2 ops in flight → `out_valid = 0` immediately, no result appears afterwards, and `in_ready = 1` after release.
